// File: rtl/piece_move_if.sv
// Handshake bundle between the piece-move controller and the keyboard /
// position datapath. The controller drives the command side.
interface piece_move_if;
  logic [7:0] keycode;
  logic       cmd_ready;
  logic       cmd_blocked;
  logic       spawn_ok;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       spawn_req;
  logic       lock_req;
  logic       game_over;
  logic [2:0] ctrl_state;

  modport master (
    input  keycode, cmd_ready, cmd_blocked, spawn_ok,
    output cmd_valid, cmd, spawn_req, lock_req, game_over, ctrl_state
  );

  modport slave (
    output keycode, cmd_ready, cmd_blocked, spawn_ok,
    input  cmd_valid, cmd, spawn_req, lock_req, game_over, ctrl_state
  );
endinterface

// File: rtl/piece_move_ctrl.sv
// Per-frame falling-piece controller: key debounce with DAS/ARR, gravity,
// lock delay and spawn/lock sequencing, one command per valid/ready transfer.
//
// state | meaning
// IDLE  | post-reset, heads to SPAWN on the next frame
// SPAWN | spawn_req high, waiting on spawn_ok
// FALL  | piece falling; gravity and keys active
// LOCK  | piece grounded; lock timer running, keys still active
// OVER  | failed spawn; held until Reset
module piece_move_ctrl #(
  parameter int GRAVITY_FRAMES   = 30,
  parameter int SOFT_DROP_FRAMES = 2,
  parameter int DAS_FRAMES       = 10,
  parameter int ARR_FRAMES       = 3,
  parameter int LOCK_FRAMES      = 15
) (
  input  logic        frame_clk,
  input  logic        Reset,
  piece_move_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_FALL  = 3'd2,
    ST_LOCK  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_LEFT  = 3'd1;
  localparam logic [2:0] CMD_RIGHT = 3'd2;
  localparam logic [2:0] CMD_ROT   = 3'd3;
  localparam logic [2:0] CMD_DOWN  = 3'd4;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_ROT   = 8'h1A;
  localparam logic [7:0] KEY_SOFT  = 8'h16;

  localparam logic [7:0] GRAV_C = 8'(GRAVITY_FRAMES);
  localparam logic [7:0] SOFT_C = 8'(SOFT_DROP_FRAMES);
  localparam logic [7:0] DAS_C  = 8'(DAS_FRAMES);
  localparam logic [7:0] ARR_C  = 8'(ARR_FRAMES);
  localparam logic [7:0] LOCK_C = 8'(LOCK_FRAMES);

  state_t     state_q, state_d;
  logic [7:0] key_prev_q, key_prev_d;
  logic [7:0] das_q, das_d;
  logic [7:0] arr_q, arr_d;
  logic [7:0] grav_q, grav_d;
  logic [7:0] lock_q, lock_d;
  logic       pend_left_q, pend_left_d;
  logic       pend_right_q, pend_right_d;
  logic       pend_rot_q, pend_rot_d;
  logic       pend_down_q, pend_down_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [2:0] cmd_q, cmd_d;
  logic       spawn_req_q, spawn_req_d;
  logic       lock_req_q, lock_req_d;
  logic       game_over_q, game_over_d;

  logic       is_left, is_right, is_rot, is_soft, is_move, press, held_shift;
  logic       rep_fire;
  logic [7:0] period;

  assign is_left    = (bus.keycode == KEY_LEFT);
  assign is_right   = (bus.keycode == KEY_RIGHT);
  assign is_rot     = (bus.keycode == KEY_ROT);
  assign is_soft    = (bus.keycode == KEY_SOFT);
  assign is_move    = is_left | is_right | is_rot | is_soft;
  assign press      = is_move && (bus.keycode != key_prev_q);
  assign held_shift = (is_left | is_right) && (bus.keycode == key_prev_q);
  assign period     = is_soft ? SOFT_C : GRAV_C;

  always_comb begin
    state_d      = state_q;
    key_prev_d   = bus.keycode;
    das_d        = das_q;
    arr_d        = arr_q;
    grav_d       = grav_q;
    lock_d       = lock_q;
    pend_left_d  = pend_left_q;
    pend_right_d = pend_right_q;
    pend_rot_d   = pend_rot_q;
    pend_down_d  = pend_down_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_d        = cmd_q;
    lock_req_d   = 1'b0;
    rep_fire     = 1'b0;

    case (state_q)
      ST_IDLE:  state_d = ST_SPAWN;
      ST_SPAWN: begin
        if (bus.spawn_ok) begin
          state_d = ST_FALL;
          grav_d  = 8'd0;
        end else begin
          state_d = ST_OVER;
        end
      end
      ST_FALL, ST_LOCK: begin
        // Issue from registered flags; fresh key/gravity events below win over the clear.
        if (!cmd_valid_q) begin
          if (pend_rot_q) begin
            cmd_d = CMD_ROT;   cmd_valid_d = 1'b1; pend_rot_d = 1'b0;
          end else if (pend_left_q) begin
            cmd_d = CMD_LEFT;  cmd_valid_d = 1'b1; pend_left_d = 1'b0;
          end else if (pend_right_q) begin
            cmd_d = CMD_RIGHT; cmd_valid_d = 1'b1; pend_right_d = 1'b0;
          end else if (pend_down_q) begin
            cmd_d = CMD_DOWN;  cmd_valid_d = 1'b1; pend_down_d = 1'b0;
          end
        end

        if (press && (is_left | is_right | is_rot)) begin
          pend_left_d  = pend_left_d  | is_left;
          pend_right_d = pend_right_d | is_right;
          pend_rot_d   = pend_rot_d   | is_rot;
          das_d        = 8'd0;
        end else if (held_shift) begin
          if (das_q < DAS_C) begin
            das_d = das_q + 8'd1;
            if (das_q + 8'd1 == DAS_C) begin
              rep_fire = 1'b1;
              arr_d    = 8'd0;
            end
          end else if (arr_q + 8'd1 >= ARR_C) begin
            rep_fire = 1'b1;
            arr_d    = 8'd0;
          end else begin
            arr_d = arr_q + 8'd1;
          end
        end
        if (rep_fire) begin
          pend_left_d  = pend_left_d  | is_left;
          pend_right_d = pend_right_d | is_right;
        end

        // >= lets a shortened period fire at once when the count is already past it.
        if (state_q == ST_FALL) begin
          if (grav_q >= period - 8'd1) begin
            pend_down_d = 1'b1;
            grav_d      = 8'd0;
          end else begin
            grav_d = grav_q + 8'd1;
          end
        end

        if (cmd_valid_q && bus.cmd_ready) begin
          cmd_valid_d = 1'b0;
          cmd_d       = CMD_NONE;
          if (cmd_q == CMD_DOWN) begin
            if (bus.cmd_blocked) begin
              state_d     = ST_LOCK;
              lock_d      = 8'd0;
              pend_down_d = 1'b0;
            end else if (state_q == ST_LOCK) begin
              state_d = ST_FALL;
              grav_d  = 8'd0;
            end
          end else if (!bus.cmd_blocked && state_q == ST_LOCK) begin
            state_d     = ST_FALL;
            grav_d      = 8'd0;
            pend_down_d = 1'b1;
          end
        end

        if (state_q == ST_LOCK && !cmd_valid_q) begin
          if (lock_q >= LOCK_C - 8'd1) begin
            lock_req_d   = 1'b1;
            state_d      = ST_SPAWN;
            pend_left_d  = 1'b0;
            pend_right_d = 1'b0;
            pend_rot_d   = 1'b0;
            pend_down_d  = 1'b0;
            cmd_valid_d  = 1'b0;
            cmd_d        = CMD_NONE;
          end else begin
            lock_d = lock_q + 8'd1;
          end
        end
      end
      ST_OVER: state_d = ST_OVER;
      default: state_d = ST_IDLE;
    endcase

    spawn_req_d = (state_d == ST_SPAWN);
    game_over_d = game_over_q | (state_d == ST_OVER);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      key_prev_q   <= 8'd0;
      das_q        <= 8'd0;
      arr_q        <= 8'd0;
      grav_q       <= 8'd0;
      lock_q       <= 8'd0;
      pend_left_q  <= 1'b0;
      pend_right_q <= 1'b0;
      pend_rot_q   <= 1'b0;
      pend_down_q  <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_q        <= CMD_NONE;
      spawn_req_q  <= 1'b0;
      lock_req_q   <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_prev_q   <= key_prev_d;
      das_q        <= das_d;
      arr_q        <= arr_d;
      grav_q       <= grav_d;
      lock_q       <= lock_d;
      pend_left_q  <= pend_left_d;
      pend_right_q <= pend_right_d;
      pend_rot_q   <= pend_rot_d;
      pend_down_q  <= pend_down_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_q        <= cmd_d;
      spawn_req_q  <= spawn_req_d;
      lock_req_q   <= lock_req_d;
      game_over_q  <= game_over_d;
    end
  end

  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd        = cmd_q;
  assign bus.spawn_req  = spawn_req_q;
  assign bus.lock_req   = lock_req_q;
  assign bus.game_over  = game_over_q;
  assign bus.ctrl_state = state_q;

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Directed bench for piece_move_ctrl: gravity, DAS/ARR, lock delay,
// lock-exit on a free move, backpressure, game over and async reset.
module tb_piece_move_ctrl;
  logic frame_clk = 1'b0;
  logic Reset = 1'b1;

  piece_move_if bus_if();

  piece_move_ctrl #(
    .GRAVITY_FRAMES(30), .SOFT_DROP_FRAMES(2), .DAS_FRAMES(10),
    .ARR_FRAMES(3), .LOCK_FRAMES(15)
  ) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .bus(bus_if)
  );

  always #5 frame_clk = ~frame_clk;

  int total = 0;
  int bad = 0;
  int acc[8];
  int n_lock = 0;
  int down_in_lock = 0;
  bit ok;
  bit stable;
  logic [7:0] keys[5];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n frames, sampling 1ns after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge frame_clk);
      #1;
      if (bus_if.cmd_valid && bus_if.cmd_ready) acc[int'(bus_if.cmd)]++;
      if (bus_if.lock_req) n_lock++;
      if (bus_if.cmd_valid && bus_if.ctrl_state == 3'd3 && bus_if.cmd == 3'd4) down_in_lock++;
    end
  endtask

  task automatic wait_down(output bit found);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus_if.cmd_valid && bus_if.cmd == 3'd4) begin
        found = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) acc[i] = 0;
    bus_if.keycode     = 8'h00;
    bus_if.cmd_ready   = 1'b1;
    bus_if.cmd_blocked = 1'b0;
    bus_if.spawn_ok    = 1'b1;

    // reset values and bring-up
    repeat (2) @(posedge frame_clk);
    #1;
    chk("rst_state", {5'd0, bus_if.ctrl_state}, 8'd0);
    chk("rst_outs", {3'd0, bus_if.cmd_valid, bus_if.spawn_req, bus_if.lock_req,
                     bus_if.game_over, 1'b0}, 8'd0);
    chk("rst_cmd", {5'd0, bus_if.cmd}, 8'd0);
    Reset = 1'b0;
    step(1);
    chk("spawn_state", {5'd0, bus_if.ctrl_state}, 8'd1);
    chk("spawn_req", {7'd0, bus_if.spawn_req}, 8'd1);
    step(1);
    chk("fall_state", {5'd0, bus_if.ctrl_state}, 8'd2);
    chk("spawn_req_off", {7'd0, bus_if.spawn_req}, 8'd0);

    // gravity: one DOWN every 30 frames
    step(30);
    chk("grav_not_yet", {7'd0, bus_if.cmd_valid}, 8'd0);
    step(1);
    chk("grav_valid1", {7'd0, bus_if.cmd_valid}, 8'd1);
    chk("grav_cmd1", {5'd0, bus_if.cmd}, 8'd4);
    step(29);
    chk("grav_gap", {7'd0, bus_if.cmd_valid}, 8'd0);
    step(1);
    chk("grav_valid2", {7'd0, bus_if.cmd_valid}, 8'd1);
    chk("grav_count", 8'(acc[4]), 8'd2);
    chk("grav_still_fall", {5'd0, bus_if.ctrl_state}, 8'd2);

    // left held 20 frames: frames 1, 11, 14, 17, 20
    bus_if.keycode = 8'h04;
    step(20);
    chk("das_left_4", 8'(acc[1]), 8'd4);
    bus_if.keycode = 8'h00;
    step(4);
    chk("das_left_5", 8'(acc[1]), 8'd5);

    // rotate held 20 frames: single command
    bus_if.keycode = 8'h1A;
    step(20);
    bus_if.keycode = 8'h00;
    step(3);
    chk("rot_once", 8'(acc[3]), 8'd1);
    chk("left_unchanged", 8'(acc[1]), 8'd5);

    // blocked DOWN -> LOCK, lock_req 15 frames later
    bus_if.cmd_blocked = 1'b1;
    wait_down(ok);
    chk("wait_down1", {7'd0, ok}, 8'd1);
    step(1);
    chk("lock_enter", {5'd0, bus_if.ctrl_state}, 8'd3);
    chk("lock_no_cmd", {7'd0, bus_if.cmd_valid}, 8'd0);
    step(14);
    chk("lock_early", {7'd0, bus_if.lock_req}, 8'd0);
    chk("lock_early_n", 8'(n_lock), 8'd0);
    step(1);
    chk("lock_pulse", {7'd0, bus_if.lock_req}, 8'd1);
    chk("lock_to_spawn", {5'd0, bus_if.ctrl_state}, 8'd1);
    step(1);
    chk("lock_pulse_end", {7'd0, bus_if.lock_req}, 8'd0);
    chk("respawn_fall", {5'd0, bus_if.ctrl_state}, 8'd2);

    // free RIGHT in LOCK -> FALL, re-probe DOWN, lock timer restarts
    wait_down(ok);
    chk("wait_down2", {7'd0, ok}, 8'd1);
    step(1);
    chk("lock2_enter", {5'd0, bus_if.ctrl_state}, 8'd3);
    bus_if.cmd_blocked = 1'b0;
    bus_if.keycode = 8'h07;
    step(1);
    bus_if.keycode = 8'h00;
    step(1);
    chk("right_valid", {7'd0, bus_if.cmd_valid}, 8'd1);
    chk("right_cmd", {5'd0, bus_if.cmd}, 8'd2);
    step(1);
    chk("lock_exit", {5'd0, bus_if.ctrl_state}, 8'd2);
    step(1);
    chk("reprobe_down", {4'd0, bus_if.cmd_valid, bus_if.cmd}, 8'h0C);
    bus_if.cmd_blocked = 1'b1;
    step(1);
    chk("relock", {5'd0, bus_if.ctrl_state}, 8'd3);
    step(14);
    chk("relock_early", {7'd0, bus_if.lock_req}, 8'd0);
    step(1);
    chk("relock_pulse", {7'd0, bus_if.lock_req}, 8'd1);
    chk("lock_total", 8'(n_lock), 8'd2);
    step(1);
    chk("fall3", {5'd0, bus_if.ctrl_state}, 8'd2);

    // backpressure: ROT_CW held stable, DOWN follows acceptance
    bus_if.cmd_blocked = 1'b0;
    bus_if.cmd_ready = 1'b0;
    bus_if.keycode = 8'h1A;
    step(1);
    bus_if.keycode = 8'h16;
    step(1);
    chk("bp_rot", {4'd0, bus_if.cmd_valid, bus_if.cmd}, 8'h0B);
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (!(bus_if.cmd_valid === 1'b1 && bus_if.cmd === 3'd3)) stable = 1'b0;
    end
    chk("bp_stable", {7'd0, stable}, 8'd1);
    bus_if.cmd_ready = 1'b1;
    bus_if.keycode = 8'h00;
    step(1);
    chk("bp_accept", {7'd0, bus_if.cmd_valid}, 8'd0);
    step(1);
    chk("bp_down_next", {4'd0, bus_if.cmd_valid, bus_if.cmd}, 8'h0C);

    // failed spawn -> OVER, sticky under any key
    bus_if.cmd_blocked = 1'b1;
    wait_down(ok);
    chk("wait_down3", {7'd0, ok}, 8'd1);
    step(1);
    chk("lock3_enter", {5'd0, bus_if.ctrl_state}, 8'd3);
    step(15);
    chk("lock3_pulse", {7'd0, bus_if.lock_req}, 8'd1);
    bus_if.spawn_ok = 1'b0;
    step(1);
    chk("over_state", {5'd0, bus_if.ctrl_state}, 8'd4);
    chk("over_flag", {7'd0, bus_if.game_over}, 8'd1);
    chk("over_spawn_req", {7'd0, bus_if.spawn_req}, 8'd0);
    keys[0] = 8'h04; keys[1] = 8'h07; keys[2] = 8'h1A; keys[3] = 8'h16; keys[4] = 8'hFF;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_if.keycode = keys[i];
      step(2);
      if (!(bus_if.ctrl_state === 3'd4 && bus_if.game_over === 1'b1 &&
            bus_if.cmd_valid === 1'b0 && bus_if.spawn_req === 1'b0)) stable = 1'b0;
    end
    chk("over_sticky", {7'd0, stable}, 8'd1);
    chk("no_down_in_lock", 8'(down_in_lock), 8'd0);

    // reset clears game over
    bus_if.keycode = 8'h00;
    Reset = 1'b1;
    #1;
    chk("rst_over", {4'd0, bus_if.ctrl_state, bus_if.game_over}, 8'd0);
    #2;
    Reset = 1'b0;
    bus_if.spawn_ok = 1'b1;
    bus_if.cmd_blocked = 1'b0;
    step(2);
    chk("fall4", {5'd0, bus_if.ctrl_state}, 8'd2);

    // async reset with a command in flight
    wait_down(ok);
    chk("wait_down4", {7'd0, ok}, 8'd1);
    Reset = 1'b1;
    #1;
    chk("midrst_outs", {3'd0, bus_if.cmd_valid, bus_if.spawn_req, bus_if.lock_req,
                        bus_if.game_over, 1'b0}, 8'd0);
    chk("midrst_cmd_state", {2'd0, bus_if.cmd, bus_if.ctrl_state}, 8'd0);
    #1;
    Reset = 1'b0;
    step(1);
    chk("midrst_spawn", {4'd0, bus_if.ctrl_state, bus_if.spawn_req}, 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/piece_move_ctrl.md
Name: piece_move_ctrl

Overview:
- Per-frame controller that sequences the falling-piece position datapath.
- Turns the raw USB `keycode` into debounced move/rotate commands, with delayed auto-shift (DAS) and auto-repeat.
- Generates gravity ticks, runs the lock-delay timer, and drives the spawn/lock handshake.
- Sits between the keyboard interface and the piece position/collision datapath. It issues one command per frame through a valid/ready handshake.

Parameters:
- GRAVITY_FRAMES, 30, frames between gravity DOWN commands (normal fall)
- SOFT_DROP_FRAMES, 2, gravity period while the soft-drop key is held
- DAS_FRAMES, 10, frames a shift key is held before auto-repeat starts
- ARR_FRAMES, 3, frames between auto-repeat shifts after DAS expires
- LOCK_FRAMES, 15, frames a grounded piece waits before lock

Ports:
- frame_clk  input  1  frame clock; all state advances on its rising edge
- Reset  input  1  asynchronous, active-high reset
- keycode  input  8  current USB keycode; 0x04=left, 0x07=right, 0x1A=rotate, 0x16=soft drop; any other value = no key
- cmd_ready  input  1  datapath accepts cmd this cycle
- cmd_blocked  input  1  valid only when cmd_valid&&cmd_ready; 1 = the move collided and was not applied
- spawn_ok  input  1  sampled while spawn_req=1; 1 = new piece placed without collision
- cmd_valid  output  1  command pending
- cmd  output  3  0=NONE, 1=LEFT, 2=RIGHT, 3=ROT_CW, 4=DOWN
- spawn_req  output  1  request a new piece
- lock_req  output  1  one-cycle pulse: write the piece into the playfield
- game_over  output  1  sticky; set on failed spawn
- ctrl_state  output  3  current state, for debug/HUD

Behaviour:
- States, encoded 0..4:
  - IDLE=0, SPAWN=1, FALL=2, LOCK=3, OVER=4.
- Reset (async) values:
  - State IDLE.
  - All outputs 0; cmd=NONE.
  - All counters 0; key_prev=0; pending flags cleared.
- Reset asserted mid-operation aborts everything immediately, including any in-flight cmd.
- IDLE → SPAWN unconditionally on the next edge.
- SPAWN:
  - spawn_req=1.
  - If spawn_ok=1 → FALL, with gravity counter cleared.
  - Else → OVER.
  - spawn_req is 1 only in SPAWN.
- OVER:
  - game_over=1, cmd_valid=0, spawn_req=0.
  - Held until Reset.
- Key decode, evaluated in FALL and LOCK only:
  - A "press" is a keycode that is a move key and differs from key_prev.
  - key_prev is updated every cycle.
  - A press of left/right/rotate sets the matching pending flag and clears the DAS counter.
  - Left/right held unchanged: the DAS counter increments each frame and saturates at DAS_FRAMES. It re-sets the pending flag when it reaches DAS_FRAMES, then every ARR_FRAMES frames after that.
  - Rotate never repeats.
  - Soft drop held selects SOFT_DROP_FRAMES as the gravity period, otherwise GRAVITY_FRAMES. On a period change, a counter ≥ the new period fires immediately.
- Gravity (FALL only):
  - 8-bit counter counts 0..period-1.
  - At period-1 it sets pend_down and wraps to 0.
- Command issue:
  - When cmd_valid=0 and any flag is pending, select one by priority ROT_CW > LEFT > RIGHT > DOWN.
  - Assert cmd_valid on the next cycle and clear that flag.
  - cmd and cmd_valid are held stable until cmd_ready=1; the cmd_valid&&cmd_ready cycle is the acceptance.
  - Unselected flags stay pending.
  - LEFT and RIGHT pending together: LEFT wins and RIGHT stays pending.
- Acceptance results:
  - DOWN accepted, cmd_blocked=1 → LOCK, lock counter=0.
  - DOWN accepted, cmd_blocked=0 → stay in FALL.
  - In LOCK, an accepted LEFT/RIGHT/ROT_CW with cmd_blocked=0 → FALL, with gravity counter cleared and pend_down set (re-probe the ground).
  - A blocked shift/rotate changes nothing.
- LOCK:
  - Gravity halted.
  - Lock counter increments each frame, but not while cmd_valid=1.
  - At LOCK_FRAMES-1: lock_req=1 for exactly one cycle, clear all pending flags and cmd_valid → SPAWN.
- Leaving FALL/LOCK by lock or to OVER drops any unaccepted command.
- The outstanding cmd is never changed while cmd_valid=1.

Test Plan:
- Reset mid-FALL with cmd_valid=1 → all outputs 0 immediately; ctrl_state=IDLE, then SPAWN; spawn_req=1 on the following edge.
- spawn_ok=1, cmd_ready=1, cmd_blocked=0, no key → cmd=DOWN with cmd_valid=1 on one cycle every 30 frames; never in LOCK.
- Hold 0x04 for 20 frames, cmd_ready=1 → LEFT issued on frame 1, then frames 11, 14, 17, 20 (5 total); 0x1A held 20 frames → exactly one ROT_CW.
- DOWN accepted with cmd_blocked=1, no keys → ctrl_state=LOCK; lock_req pulses exactly once 15 frames later; then SPAWN.
- In LOCK, press 0x07 with cmd_blocked=0 → RIGHT accepted; return to FALL; DOWN issued next; lock timer restarts on the re-block.
- cmd_ready=0 for 5 frames with ROT_CW pending and a gravity tick arriving → cmd stays ROT_CW and stable; DOWN issued right after acceptance.
- spawn_ok=0 in SPAWN → game_over=1, ctrl_state=OVER; stays there under any keycode until Reset.
